// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave receive path.
package spi_pkg;

  typedef enum logic {IDLE, ACTIVE} spi_rx_state_t;

  localparam int SYNC_STAGES = 2;
  localparam int SPI_DATA_W  = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and registered occupancy flags.
// A write into a full FIFO is accepted only when a read is accepted in the same cycle.
module sync_fifo #(
  parameter int DATA  = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr,
  input  logic [DATA-1:0] wdata,
  input  logic            rd,
  output logic [DATA-1:0] rdata,
  output logic [AW:0]     usedw,
  output logic            full,
  output logic            empty
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE     = (AW + 1)'(1);

  logic [DATA-1:0] mem [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     count_d;
  logic            rd_ok, wr_ok;

  assign rd_ok = rd & ~empty;
  assign wr_ok = wr & (~full | rd_ok);

  always_comb begin
    count_d = usedw;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = usedw + ONE;
      2'b01:   count_d = usedw - ONE;
      default: count_d = usedw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      usedw  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      rdata  <= '0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + 1'b1;
      if (rd_ok) begin
        rptr_q <= rptr_q + 1'b1;
        rdata  <= mem[rptr_q];
      end
      usedw <= count_d;
      full  <= (count_d == DEPTH_C);
      empty <= (count_d == '0);
    end
  end

  // Storage is not reset; occupancy tracking guards every read.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: oversampled pins, MSB-first deserializer and a word FIFO
// that the downstream checker stage drains through rd/rdata/usedw.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA  = SPI_DATA_W,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sclk,
  input  logic            cs_n,
  input  logic            mosi,
  input  logic            rd,
  output logic [DATA-1:0] rdata,
  output logic [AW:0]     usedw,
  output logic            full,
  output logic            overflow,
  output logic            frame_done
);

  localparam int            CW       = $clog2(DATA);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA - 1);

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_prev;
  logic                   sclk_s, cs_s, mosi_s, sclk_rise;

  spi_rx_state_t   state_q;
  logic [CW-1:0]   bit_cnt_q;
  logic [DATA-1:0] shreg_q;
  logic            wr_q;
  logic            word_flag_q;
  logic            fifo_empty;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;

  // cs_n synchronizer resets to the deasserted level so reset never fakes a frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      wr_q        <= 1'b0;
      word_flag_q <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      wr_q       <= 1'b0;
      frame_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!cs_s) begin
            state_q     <= ACTIVE;
            bit_cnt_q   <= '0;
            word_flag_q <= 1'b0;
          end
        end
        ACTIVE: begin
          if (cs_s) begin
            state_q    <= IDLE;
            frame_done <= word_flag_q;
          end else if (sclk_rise) begin
            shreg_q <= {shreg_q[DATA-2:0], mosi_s};
            if (bit_cnt_q == LAST_BIT) begin
              wr_q        <= 1'b1;
              bit_cnt_q   <= '0;
              word_flag_q <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // The shift register is stable for the write cycle: sclk edges are at least 4 clk apart.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wr_q && full && !(rd && !fifo_empty)) begin
      overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .DATA  (DATA),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (wr_q),
    .wdata (shreg_q),
    .rd    (rd),
    .rdata (rdata),
    .usedw (usedw),
    .full  (full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: table-driven single-word frames, hand-written
// corner sequences and random frames against a transaction-level queue model.
module tb_spi_slave_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] rdata;
  logic [4:0] usedw;
  logic       full, overflow, frame_done;

  spi_slave_rx dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .rd         (rd),
    .rdata      (rdata),
    .usedw      (usedw),
    .full       (full),
    .overflow   (overflow),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  // Reference model: FIFO contents, sticky overflow, last popped word, frame_done count.
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic [7:0] m_rdata = 8'h00;
  int         m_fd = 0;

  typedef struct {
    logic [7:0] data;
    int         nbits;
    int         exp_usedw;
    int         exp_fd;
    logic [7:0] exp_rdata;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_word(input logic [7:0] b);
    if (q.size() < 16) q.push_back(b);
    else m_ovf = 1'b1;
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_rdata = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; rd = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);
    model_reset();
  endtask

  // Sends the top n bits of d, MSB first; sclk low 4 clk then high 4 clk per bit.
  // rd_last pulses rd for exactly the cycle in which the last bit's word is written.
  task automatic shift_bits(input logic [7:0] d, input int n, input bit rd_last);
    for (int i = 0; i < n; i++) begin
      mosi = d[7-i];
      sclk = 1'b0;
      tick(4);
      sclk = 1'b1;
      if (rd_last && i == n - 1) begin
        tick(3);
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
      end else begin
        tick(4);
      end
    end
    sclk = 1'b0;
  endtask

  task automatic frame_begin();
    cs_n = 1'b0;
    tick(4);
  endtask

  task automatic frame_end();
    sclk = 1'b0;
    tick(4);
    cs_n = 1'b1;
    tick(8);
  endtask

  task automatic send_frame1(input logic [7:0] b);
    frame_begin();
    shift_bits(b, 8, 1'b0);
    model_word(b);
    frame_end();
    m_fd++;
  endtask

  task automatic chk_state(input string name);
    chk({name, ".usedw"}, 32'(usedw), 32'(q.size()));
    chk({name, ".full"}, 32'(full), 32'(q.size() == 16));
    chk({name, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({name, ".frame_done_count"}, 32'(fd_cnt), 32'(m_fd));
  endtask

  task automatic read_chk(input string name);
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    if (q.size() > 0) m_rdata = q.pop_front();
    chk({name, ".rdata"}, 32'(rdata), 32'(m_rdata));
    chk({name, ".usedw"}, 32'(usedw), 32'(q.size()));
  endtask

  initial begin
    vecs[0] = '{8'h00, 8, 1, 1, 8'h00};
    vecs[1] = '{8'hFF, 8, 1, 1, 8'hFF};
    vecs[2] = '{8'h80, 8, 1, 1, 8'h80};
    vecs[3] = '{8'h01, 8, 1, 1, 8'h01};
    vecs[4] = '{8'h3C, 7, 0, 0, 8'h00};
    vecs[5] = '{8'hC3, 1, 0, 0, 8'h00};
    vecs[6] = '{8'h96, 8, 1, 1, 8'h96};
    vecs[7] = '{8'h6B, 0, 0, 0, 8'h00};

    // Reset and idle
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("reset.rdata", 32'(rdata), 0);
    chk("reset.usedw", 32'(usedw), 0);
    chk("reset.full", 32'(full), 0);
    chk("reset.overflow", 32'(overflow), 0);
    chk("reset.frame_done", 32'(frame_done), 0);
    shift_bits(8'hA5, 8, 1'b0);
    tick(8);
    chk_state("idle_sclk");

    // Nominal frame 0x31..0x39
    frame_begin();
    for (int b = 8'h31; b <= 8'h39; b++) begin
      shift_bits(8'(b), 8, 1'b0);
      model_word(8'(b));
    end
    frame_end();
    m_fd++;
    chk_state("nominal");
    for (int i = 0; i < 9; i++) read_chk("nominal_read");

    // Aborted byte followed by a clean frame
    frame_begin();
    shift_bits(8'hFF, 5, 1'b0);
    frame_end();
    chk_state("aborted");
    send_frame1(8'hA5);
    chk_state("after_abort");
    read_chk("after_abort_read");

    // Table of single-word frames, including partial and empty frames
    for (int v = 0; v < 8; v++) begin
      int fd0;
      fd0 = fd_cnt;
      frame_begin();
      shift_bits(vecs[v].data, vecs[v].nbits, 1'b0);
      frame_end();
      chk("vec.usedw", 32'(usedw), 32'(vecs[v].exp_usedw));
      chk("vec.frame_done", 32'(fd_cnt - fd0), 32'(vecs[v].exp_fd));
      m_fd = m_fd + vecs[v].exp_fd;
      if (vecs[v].exp_usedw > 0) begin
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
        chk("vec.rdata", 32'(rdata), 32'(vecs[v].exp_rdata));
        chk("vec.usedw_after_rd", 32'(usedw), 0);
        m_rdata = vecs[v].exp_rdata;
      end
    end

    // Latency: the write lands on the 4th edge after sclk is first sampled high
    frame_begin();
    shift_bits(8'h42, 7, 1'b0);
    mosi = 1'b0;
    tick(4);
    sclk = 1'b1;
    tick(3);
    chk("latency.edge3", 32'(usedw), 0);
    tick(1);
    chk("latency.edge4", 32'(usedw), 1);
    model_word(8'h42);
    frame_end();
    m_fd++;
    chk_state("latency");
    read_chk("latency_read");

    // rd on empty leaves rdata unchanged
    read_chk("rd_empty");

    // Full FIFO with rd in the write cycle: no overflow, occupancy unchanged
    do_reset();
    frame_begin();
    for (int i = 0; i < 16; i++) begin
      shift_bits(8'(8'h80 + i), 8, 1'b0);
      model_word(8'(8'h80 + i));
    end
    shift_bits(8'hC7, 8, 1'b1);
    m_rdata = q.pop_front();
    q.push_back(8'hC7);
    frame_end();
    m_fd++;
    chk("rd_on_full.rdata", 32'(rdata), 32'(m_rdata));
    chk_state("rd_on_full");
    for (int i = 0; i < 16; i++) read_chk("rd_on_full_drain");
    read_chk("rd_on_full_empty");

    // Random frames with interleaved reads
    for (int f = 0; f < 20; f++) begin
      int nb, part, nr;
      nb = $urandom_range(0, 3);
      part = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
      frame_begin();
      for (int i = 0; i < nb; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        shift_bits(b, 8, 1'b0);
        model_word(b);
      end
      shift_bits(8'($urandom), part, 1'b0);
      frame_end();
      if (nb > 0) m_fd++;
      chk_state("random");
      nr = $urandom_range(0, q.size() + 1);
      for (int i = 0; i < nr; i++) read_chk("random_read");
    end

    // Overflow: 18 words into a 16-deep FIFO without reads
    do_reset();
    frame_begin();
    for (int i = 0; i < 18; i++) begin
      shift_bits(8'(i), 8, 1'b0);
      model_word(8'(i));
    end
    frame_end();
    m_fd++;
    chk("overflow.usedw", 32'(usedw), 16);
    chk("overflow.flag", 32'(overflow), 1);
    chk_state("overflow");
    for (int i = 0; i < 16; i++) read_chk("overflow_drain");
    chk_state("overflow_after_drain");

    // Reset in the middle of a word with data queued
    do_reset();
    frame_begin();
    for (int i = 0; i < 4; i++) begin
      shift_bits(8'(8'hE0 + i), 8, 1'b0);
      model_word(8'(8'hE0 + i));
    end
    frame_end();
    m_fd++;
    chk_state("pre_midreset");
    frame_begin();
    shift_bits(8'hFF, 3, 1'b0);
    rst = 1'b1;
    cs_n = 1'b1;
    sclk = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(4);
    model_reset();
    chk_state("midreset");
    chk("midreset.rdata", 32'(rdata), 0);
    send_frame1(8'h5A);
    chk_state("after_midreset");
    read_chk("after_midreset_read");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
